// File: rtl/sm_run_ctrl.sv
// Run/step/halt sequencer that drives the CPU core with a one-cycle clock-enable strobe.
// Define SM_RUN_CTRL_BREAK_EN to build the PC-match breakpoint and the BREAK state.
module sm_run_ctrl #(
  parameter int DEBOUNCE = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_key,
  input  logic [3:0]       divide,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_en,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] tick_cnt
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE);

  state_t            r_state;
  state_t            w_state_nx;
  logic              r_cpu_en;
  logic [CNT_W-1:0]  r_tick_cnt;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_db_lvl;
  logic              r_db_lvl_d;
  logic [DB_W-1:0]   r_db_cnt;
  logic              w_step_pulse;

  logic [14:0]       r_div_cnt;
  logic [14:0]       w_div_term;
  logic              w_counting;
  logic              w_tick_now;
  logic              w_bp_block;
  logic              w_issue;

  // Step key: two-flop synchroniser, then a level debouncer that restarts on any reversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_lvl   <= 1'b0;
      r_db_lvl_d <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_sync1    <= step_key;
      r_sync2    <= r_sync1;
      r_db_lvl_d <= r_db_lvl;
      if (r_sync2 == r_db_lvl) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE - 1)) begin
        r_db_lvl <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_step_pulse = r_db_lvl & ~r_db_lvl_d;

  // A shift of 15 wraps to zero in 15 bits, so the terminal value becomes all-ones.
  assign w_div_term = (15'd1 << divide) - 15'd1;
  assign w_counting = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_tick_now = w_counting && (r_div_cnt == w_div_term);

`ifdef SM_RUN_CTRL_BREAK_EN
  logic r_bp_skip;
  logic w_set_skip;

  assign w_bp_block = bp_en && (pc == bp_addr) && !r_bp_skip && (r_state == ST_RUN);
  assign w_set_skip = (r_state == ST_BREAK) &&
                      ((w_state_nx == ST_RUN) || (w_state_nx == ST_STEP));

  // Skip lets the resumed core execute the breakpoint instruction once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bp_skip <= 1'b0;
    end else if (w_set_skip) begin
      r_bp_skip <= 1'b1;
    end else if (w_issue) begin
      r_bp_skip <= 1'b0;
    end
  end
`else
  logic w_unused_bp;

  assign w_bp_block  = 1'b0;
  assign w_unused_bp = ^{pc, bp_addr, bp_en};
`endif

  always_comb begin
    w_state_nx = r_state;
    w_issue    = w_tick_now && !w_bp_block;
    case (r_state)
      ST_HALT: begin
        if (halt_req)          w_state_nx = ST_HALT;
        else if (run_req)      w_state_nx = ST_RUN;
        else if (w_step_pulse) w_state_nx = ST_STEP;
      end
      ST_RUN: begin
        if (halt_req)                      w_state_nx = ST_HALT;
        else if (w_tick_now && w_bp_block) w_state_nx = ST_BREAK;
      end
      ST_STEP: begin
        if (halt_req)        w_state_nx = ST_HALT;
        else if (w_tick_now) w_state_nx = ST_HALT;
      end
      ST_BREAK: begin
        if (halt_req)          w_state_nx = ST_HALT;
        else if (run_req)      w_state_nx = ST_RUN;
        else if (w_step_pulse) w_state_nx = ST_STEP;
      end
      default: w_state_nx = ST_HALT;
    endcase
  end

  // Divider restarts from zero on every state change so each run/step begins aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if ((w_state_nx != r_state) || !w_counting || w_tick_now) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 15'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HALT;
      r_cpu_en   <= 1'b0;
      r_tick_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_cpu_en   <= w_issue;
      r_tick_cnt <= r_tick_cnt + CNT_W'(r_cpu_en);
    end
  end

  assign cpu_en   = r_cpu_en;
  assign state    = r_state;
  assign tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Self-checking bench for sm_run_ctrl: run latency, divider, debounced step, breakpoint,
// request priority and mid-run reset.
`timescale 1ns/1ps
module tb_sm_run_ctrl;

  localparam int DEBOUNCE = 16;
  localparam int CNT_W    = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             run_req;
  logic             halt_req;
  logic             step_key;
  logic [3:0]       divide;
  logic [31:0]      pc;
  logic [31:0]      bp_addr;
  logic             bp_en;
  logic             cpu_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] tick_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_tc = '0;
  logic [31:0] exp_q[$];

  sm_run_ctrl #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .run_req  (run_req),
    .halt_req (halt_req),
    .step_key (step_key),
    .divide   (divide),
    .pc       (pc),
    .bp_addr  (bp_addr),
    .bp_en    (bp_en),
    .cpu_en   (cpu_en),
    .state    (state),
    .tick_cnt (tick_cnt)
  );

  always #5 clk = ~clk;

  // One clock; the modelled core advances its PC by 4 whenever it sees an enable.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cpu_en === 1'b1) pc = pc + 32'd4;
  endtask

  task automatic test_reset();
    rst = 1'b1; run_req = 1'b1; step_key = 1'b1; divide = 4'd5;
    tick();
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %0b expected 0", cpu_en); end
    checks++; if (tick_cnt !== '0) begin errors++; $display("FAIL reset_tick_cnt: got %0d expected 0", tick_cnt); end
    rst = 1'b0; run_req = 1'b0; step_key = 1'b0; divide = 4'd0;
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_release_state: got %0d expected 0", state); end
    exp_tc = '0;
  endtask

  task automatic test_run_div0();
    int          low = 0;
    logic [31:0] e;
    divide = 4'd0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    exp_q.push_back(exp_tc + 32'd99);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL run_state: got %0d expected 1", state); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL run_latency_early: got %0b expected 0", cpu_en); end
    tick();
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL run_first_en: got %0b expected 1", cpu_en); end
    for (int i = 0; i < 99; i++) begin
      tick();
      if (cpu_en !== 1'b1) low++;
    end
    checks++; if (low != 0) begin errors++; $display("FAIL run_continuous: got %0d gaps expected 0", low); end
    e = exp_q.pop_front();
    checks++; if (tick_cnt !== e) begin errors++; $display("FAIL run_tick_cnt: got %0d expected %0d", tick_cnt, e); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL run_halt_state: got %0d expected 0", state); end
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL run_halt_last_en: got %0b expected 1", cpu_en); end
    tick();
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL run_halt_no_en: got %0b expected 0", cpu_en); end
    exp_tc = exp_tc + 32'd101;
    checks++; if (tick_cnt !== exp_tc) begin errors++; $display("FAIL run_halt_tick_cnt: got %0d expected %0d", tick_cnt, exp_tc); end
  endtask

  task automatic test_divide3();
    int          extra = 0;
    int          after = 0;
    logic [31:0] e;
    divide = 4'd3;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL div3_state: got %0d expected 1", state); end
    for (int k = 1; k <= 10; k++) exp_q.push_back(32'(k * 8));
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (cpu_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          e = exp_q.pop_front();
          checks++; if (32'(i) !== e) begin errors++; $display("FAIL div3_pulse_cycle: got %0d expected %0d", i, e); end
        end
      end
    end
    checks++; if ((exp_q.size() != 0) || (extra != 0)) begin
      errors++; $display("FAIL div3_pulse_count: got %0d missing, %0d extra expected 0, 0", exp_q.size(), extra);
    end
    exp_q.delete();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL div3_halt_state: got %0d expected 0", state); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_en === 1'b1) after++;
    end
    checks++; if (after != 0) begin errors++; $display("FAIL div3_after_halt: got %0d pulses expected 0", after); end
    exp_tc = exp_tc + 32'd10;
    checks++; if (tick_cnt !== exp_tc) begin errors++; $display("FAIL div3_tick_cnt: got %0d expected %0d", tick_cnt, exp_tc); end
  endtask

  task automatic test_step_debounce();
    int          pulses = 0;
    int          first = -1;
    int          seen_step = 0;
    logic [31:0] e;
    divide = 4'd0;
    for (int i = 0; i < 60; i++) begin
      step_key = ((i / 5) % 2 == 0);
      tick();
      if (cpu_en === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL step_bounce: got %0d pulses expected 0", pulses); end
    // 2 sync flops + 16 stable cycles, then one cycle each for STEP entry and the strobe.
    exp_q.push_back(32'd20);
    step_key = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (state === 2'b10) seen_step++;
      if (cpu_en === 1'b1) begin
        pulses++;
        if (first < 0) first = t;
      end
    end
    e = exp_q.pop_front();
    checks++; if (32'(first) !== e) begin errors++; $display("FAIL step_pulse_time: got %0d expected %0d", first, e); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL step_pulse_count: got %0d expected 1", pulses); end
    checks++; if (seen_step != 1) begin errors++; $display("FAIL step_state_seen: got %0d cycles expected 1", seen_step); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL step_return_halt: got %0d expected 0", state); end
    exp_tc = exp_tc + 32'd1;
    checks++; if (tick_cnt !== exp_tc) begin errors++; $display("FAIL step_tick_cnt: got %0d expected %0d", tick_cnt, exp_tc); end
    step_key = 1'b0;
    pulses = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if ((cpu_en === 1'b1) || (state !== 2'b00)) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL step_falling_edge: got %0d active cycles expected 0", pulses); end
  endtask

  task automatic test_breakpoint();
    int   n = 0;
    int   bad = 0;
    logic saw_break = 1'b0;
    pc = 32'd0; bp_addr = 32'h0000_0010; bp_en = 1'b1; divide = 4'd0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
`ifdef SM_RUN_CTRL_BREAK_EN
    while ((state !== 2'b11) && (n < 30)) begin
      tick();
      n++;
    end
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL bp_break_state: got %0d expected 3", state); end
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL bp_break_pc: got %0h expected 10", pc); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL bp_break_no_en: got %0b expected 0", cpu_en); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if ((state !== 2'b11) || (cpu_en !== 1'b0)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_break_hold: got %0d bad cycles expected 0", bad); end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL bp_resume_state: got %0d expected 1", state); end
    tick();
    checks++; if ((cpu_en !== 1'b1) || (pc !== 32'h14)) begin
      errors++; $display("FAIL bp_resume_exec: got en=%0b pc=%0h expected en=1 pc=14", cpu_en, pc);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++; if ((state !== 2'b01) || (pc !== 32'h3C)) begin
      errors++; $display("FAIL bp_run_past: got state=%0d pc=%0h expected state=1 pc=3c", state, pc);
    end
`else
    for (int i = 0; i < 30; i++) begin
      tick();
      if (state === 2'b11) saw_break = 1'b1;
    end
    checks++; if (saw_break !== 1'b0) begin errors++; $display("FAIL bp_disabled_break: got %0b expected 0", saw_break); end
    checks++; if ((state !== 2'b01) || (pc !== 32'h78)) begin
      errors++; $display("FAIL bp_disabled_run: got state=%0d pc=%0h expected state=1 pc=78", state, pc);
    end
`endif
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    bp_en = 1'b0;
    exp_tc = exp_tc + (pc >> 2);
    checks++; if ((state !== 2'b00) || (tick_cnt !== exp_tc)) begin
      errors++; $display("FAIL bp_halt: got state=%0d tick_cnt=%0d expected state=0 tick_cnt=%0d", state, tick_cnt, exp_tc);
    end
  endtask

  task automatic test_priority();
    int bad = 0;
    divide = 4'd0;
    halt_req = 1'b1; run_req = 1'b1;
    tick();
    halt_req = 1'b0; run_req = 1'b0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL prio_halt_over_run: got %0d expected 0", state); end
    tick();
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL prio_halt_no_en: got %0b expected 0", cpu_en); end
    // Raise run_req in the same cycle the debounced step pulse appears.
    step_key = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL prio_run_over_step: got %0d expected 1", state); end
    tick();
    checks++; if ((state !== 2'b01) || (cpu_en !== 1'b1)) begin
      errors++; $display("FAIL prio_run_continues: got state=%0d en=%0b expected state=1 en=1", state, cpu_en);
    end
    step_key = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    step_key = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if ((state !== 2'b01) || (cpu_en !== 1'b1)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL prio_step_in_run: got %0d disturbed cycles expected 0", bad); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    step_key = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (state !== 2'b00) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL prio_no_queued_step: got %0d non-halt cycles expected 0", bad); end
  endtask

  task automatic test_rst_midrun();
    int bad = 0;
    divide = 4'd2;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL rst_pre_state: got %0d expected 1", state); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", state); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL rst_mid_cpu_en: got %0b expected 0", cpu_en); end
    checks++; if (tick_cnt !== '0) begin errors++; $display("FAIL rst_mid_tick_cnt: got %0d expected 0", tick_cnt); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if ((state !== 2'b00) || (cpu_en !== 1'b0) || (tick_cnt !== '0)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_after: got %0d active cycles expected 0", bad); end
  endtask

  initial begin
    rst = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_key = 1'b0;
    divide = 4'd0; pc = 32'd0; bp_addr = 32'd0; bp_en = 1'b0;
    test_reset();
    test_run_div0();
    test_divide3();
    test_step_debounce();
    test_breakpoint();
    test_priority();
    test_rst_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
